// File: rtl/fetch_pc_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_if
// Instruction-memory fetch bus. One outstanding request at a time:
//   imem_req/imem_addr   fetch side -> memory, request presented
//   imem_ready           memory -> fetch side, request accepted this cycle
//   imem_rvalid/rdata    memory -> fetch side, one response per accepted req
// master: the fetch stage; slave: the instruction memory.
// ---------------------------------------------------------------------------
interface fetch_pc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc
// Program counter + instruction-fetch stage. Issues one fetch at a time on the
// imem bus, hands {pc, instr, valid} to decode, honours the decode stall and
// redirects on a taken branch (squashing in-flight/buffered fetches and
// pulsing flush_out for one cycle).
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   imem                fetch bus (master side)
//   br_taken/br_target  redirect request and address
//   stall               decode cannot accept a new instruction
//   if_valid/if_pc/if_instr  instruction presented to decode
//   flush_out           one-cycle squash pulse to younger stages
// ---------------------------------------------------------------------------
module fetch_pc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_pc_if.master  imem,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;           // next address to fetch
    logic [31:0] req_pc_q, req_pc_d;   // address of the outstanding fetch
    logic        drop_q, drop_d;       // outstanding response is stale
    logic [31:0] hold_q, hold_d;       // instruction parked while stalled
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        flush_q, flush_d;

    assign imem.imem_req  = (state_q == S_REQ);
    // pc_q only changes on accept or redirect, so the address is stable
    // while a request waits for ready.
    assign imem.imem_addr = pc_q;

    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign flush_out = flush_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        hold_d     = hold_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        flush_d    = 1'b0;

        // Decode free: output register becomes a bubble unless an
        // instruction is delivered below.
        if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        if (br_taken) begin
            // Redirect beats everything except reset, including stall.
            pc_d       = br_target & ~32'h3;
            flush_d    = 1'b1;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            case (state_q)
                S_REQ: begin
                    // Accepted this very cycle: its response must be eaten.
                    if (imem.imem_ready) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;   // IDLE, HOLD (buffer discarded)
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem.imem_ready) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!stall) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = req_pc_q;
                            if_instr_d = imem.imem_rdata;
                            state_d    = S_REQ;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // req_pc_q still names the parked instruction.
                    if (!stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = hold_q;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            hold_q     <= NOP_INSTR;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            hold_q     <= hold_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            flush_q    <= flush_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc
// Random bench for fetch_pc. A memory model answers each accepted fetch with
// addr ^ KEY after 0..2 idle cycles (plus spurious rvalids while idle). The
// reference model is the architectural PC stream: a queue holding the next
// expected fetch addresses from the last redirect point (reset or branch),
// refilled whenever a branch is issued. The monitor pops one entry per
// instruction presented to decode and checks pc/instr, plus flush, stall
// hold, bubble and bus-stability rules.
// ---------------------------------------------------------------------------
module tb_fetch_pc;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_out;

    fetch_pc_if bus();

    fetch_pc #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .imem(bus),
        .br_taken(br_taken), .br_target(br_target), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush_out(flush_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;
    logic [31:0] exp_q[$];

    // environment state
    bit          rnd = 1'b0;       // 0: zero-wait memory, no stall/branch
    bit          mon_en = 1'b0;
    bit          cadence = 1'b0;   // check 2-cycle if_valid cadence
    int          n_edge = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_delay = 0;
    int          fixed_delay = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural stream restarts at a (word-aligned) redirect address.
    task automatic redirect(input logic [31:0] start);
        logic [31:0] a;
        a = start & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    // One cycle of stimulus, called right after a falling edge.
    task automatic drive_cycle();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mem_busy) begin
            if (mem_delay == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_addr ^ KEY;
                mem_busy        = 1'b0;
            end else begin
                mem_delay--;
            end
        end else if (rnd && $urandom_range(0, 7) == 0) begin
            bus.imem_rvalid = 1'b1;          // no fetch outstanding: must be ignored
        end
        bus.imem_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (bus.imem_req && bus.imem_ready) begin
            mem_busy  = 1'b1;
            mem_addr  = bus.imem_addr;
            mem_delay = (fixed_delay >= 0) ? fixed_delay : (rnd ? int'($urandom_range(0, 2)) : 0);
        end
        stall     = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        br_taken  = 1'b0;
        br_target = $urandom;
        if (rnd && $urandom_range(0, 11) == 0) begin
            br_taken = 1'b1;
            if ($urandom_range(0, 2) == 0) br_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            redirect(br_target);
        end
    endtask

    // Monitor: evaluates each rising edge 2 time units later. Inputs are
    // still those the DUT sampled at that edge; m_* hold pre-edge outputs.
    logic        m_req = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;

    always begin
        logic [31:0] e;
        @(posedge clk);
        #2;
        if (mon_en) begin
            n_edge++;
            chk("flush_pulse", 32'(flush_out), 32'(br_taken));
            if (cadence)
                chk("valid_cadence", 32'(if_valid), 32'(n_edge >= 3 && n_edge % 2 == 1));
            if (br_taken) begin
                chk("flush_kills_valid", 32'(if_valid), 32'd0);
            end else if (stall) begin
                chk("stall_hold_valid", 32'(if_valid), 32'(m_valid));
                chk("stall_hold_pc", if_pc, m_pc);
                chk("stall_hold_instr", if_instr, m_instr);
            end else if (if_valid) begin
                e = exp_q.pop_front();
                exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
                deliveries++;
                chk("if_pc", if_pc, e);
                chk("if_instr", if_instr, e ^ KEY);
            end else begin
                chk("bubble_nop", if_instr, NOP);
            end
            if (m_req && !bus.imem_ready && !br_taken) begin
                chk("req_held", 32'(bus.imem_req), 32'd1);
                chk("addr_stable", bus.imem_addr, m_addr);
            end
        end
        m_req   = bus.imem_req;
        m_addr  = bus.imem_addr;
        m_valid = if_valid;
        m_pc    = if_pc;
        m_instr = if_instr;
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, RPC);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_pc"}, if_pc, 32'd0);
        chk({tag, "_instr"}, if_instr, NOP);
        chk({tag, "_flush"}, 32'(flush_out), 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        br_taken = 1'b0;
        br_target = '0;
        stall = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        redirect(RPC);
        #1;
        chk_reset_state("reset");
        repeat (3) @(negedge clk);
        chk_reset_state("reset_held");

        // Zero-wait memory: first delivery on the 3rd edge, then every 2nd,
        // fetching across the 32-bit wrap from RPC.
        rst = 1'b0;
        mon_en = 1'b1;
        cadence = 1'b1;
        n_edge = 0;
        drive_cycle();
        repeat (11) begin
            @(negedge clk);
            drive_cycle();
        end
        @(negedge clk);
        cadence = 1'b0;

        // Random phase: stalls, branches, ready/latency jitter.
        rnd = 1'b1;
        repeat (3000) begin
            drive_cycle();
            @(negedge clk);
        end

        // Reset while a fetch is outstanding.
        rnd = 1'b0;
        fixed_delay = 3;
        br_taken = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 20 && !mem_busy; i++) begin
            drive_cycle();
            @(negedge clk);
        end
        chk("reach_wait", 32'(mem_busy), 32'd1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_state("async_reset");
        repeat (3) @(negedge clk);
        // Release with the abandoned response arriving while in IDLE, and
        // again while in REQ without acceptance.
        rst = 1'b0;
        fixed_delay = -1;
        mem_busy = 1'b0;
        redirect(RPC);
        mon_en = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk("restart_addr", bus.imem_addr, RPC);
        d0 = deliveries;
        @(negedge clk);
        rnd = 1'b1;
        repeat (300) begin
            drive_cycle();
            @(negedge clk);
        end
        chk("post_reset_progress", 32'(deliveries - d0 > 10), 32'd1);
        chk("progress", 32'(deliveries >= 150), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
Program-counter and instruction-fetch stage that consumes the branch unit's taken flag and target, and drives the instruction memory with a single-outstanding req/ready/rvalid handshake. It delivers {pc, instr, valid} to decode and honours the hazard unit's stall. On a taken branch it redirects the PC, squashes any in-flight or buffered fetch, and emits a one-cycle flush pulse to younger stages.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, value driven on if_instr during reset and bubbles

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
br_taken  in  1  branch-taken flag from branch unit (f); redirect request
br_target  in  32  redirect address, valid when br_taken=1
stall  in  1  hazard-unit stall; decode cannot accept new instruction
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, stable while imem_req=1 and not accepted
imem_ready  in  1  memory accepts request this cycle when imem_req=1
imem_rvalid  in  1  read data valid (exactly one per accepted request)
imem_rdata  in  32  fetched instruction
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  32  address of if_instr
if_instr  out  32  instruction to decode
flush_out  out  1  one-cycle pulse: younger stages squash

Behaviour:
- Reset (async assert, sync effect on deassert): state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP_INSTR, flush_out=0. Reset mid-transaction abandons it; any later rvalid for it is ignored while in IDLE/REQ.
- Priority: rst > br_taken > imem_rvalid > stall.
- States:
  IDLE: imem_req=0; next cycle -> REQ.
  REQ: imem_req=1, imem_addr=pc. imem_ready=1 -> req_pc<=pc, pc<=pc+4 (mod 2^32), -> WAIT.
  WAIT: imem_req=0. imem_rvalid=1: if drop, discard, drop<=0, -> REQ; else if stall=0 load outputs (if_valid=1, if_pc=req_pc, if_instr=rdata), -> REQ; else latch into hold buffer, -> HOLD.
  HOLD: imem_req=0. stall=0 -> move buffer to outputs, if_valid=1, -> REQ.
- Output register: updates only when stall=0; with stall=0 and no instruction delivered that cycle, if_valid<=0 (bubble, if_instr<=NOP_INSTR). With stall=1, outputs hold.
- Redirect (br_taken=1 in any non-reset state), effective next edge:
  pc<=br_target with bits[1:0] forced to 00; flush_out<=1 for exactly one cycle; if_valid<=0 regardless of stall (flush beats stall).
  REQ not accepted -> stay REQ, imem_addr becomes target next cycle.
  REQ accepted same cycle -> drop<=1, -> WAIT (response discarded).
  WAIT, rvalid=0 -> drop<=1, stay WAIT.
  WAIT, rvalid=1 same cycle -> data discarded, -> REQ.
  HOLD -> buffer discarded, -> REQ.
  IDLE -> pc<=target, -> REQ.
- Back-to-back br_taken: each cycle's target overrides previous; flush_out stays high each following cycle.
- Latency: zero-wait memory (ready=1, rvalid next cycle) yields one instruction every 2 cycles; first if_valid at 3rd edge after reset release.
- imem_rvalid outside WAIT: ignored.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Test Plan:
- Reset release, ready=1, rvalid 1 cycle after accept, rdata=addr^32'hA5A5A5A5 -> imem_addr sequence 0,4,8; if_pc 0,4,8 with matching instr; if_valid pulses every 2nd cycle.
- stall=1 held 3 cycles while instr @0x8 returns -> HOLD; outputs frozen at 0x4; after stall drops, if_pc=0x8 next edge, no fetch lost/duplicated.
- br_taken=1, target=0x103 while in WAIT for 0xC -> flush_out 1 cycle, 0xC response discarded, next imem_addr=0x100, if_pc=0x100 next.
- br_taken same cycle as accept of 0x10 with target 0x40 -> 0x10 data never reaches if_instr; next request 0x40.
- br_taken during HOLD with stall=1 -> if_valid=0 next edge despite stall, buffer dropped, fetch at target.
- RESET_PC=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000; rst asserted in WAIT -> outputs reset immediately, late rvalid ignored, fetch restarts at RESET_PC.
